// File: rtl/urcpu_pkg.sv
// Shared URCPU datapath constants: default register-file geometry and the
// hard-wired zero register index.
package urcpu_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefNregs = 8;
    localparam int unsigned R0Idx    = 0;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_2r1w_sb_if.sv
// Decode/writeback-facing bundle of the 2-read 1-write scoreboarded register file.
interface regfile_2r1w_sb_if
    import urcpu_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned NREGS = DefNregs
);
    localparam int unsigned AW = addr_width(NREGS);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;
    logic             rd_req;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic             rd_stall;
    logic             rd_valid;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;

    modport master (
        output we, waddr, wdata, claim_en, claim_addr, rd_req, rs1_addr, rs2_addr,
        input  rd_stall, rd_valid, rs1_data, rs2_data
    );

    modport slave (
        input  we, waddr, wdata, claim_en, claim_addr, rd_req, rs1_addr, rs2_addr,
        output rd_stall, rd_valid, rs1_data, rs2_data
    );

endinterface

// File: rtl/regfile_cell.sv
// Single register-file entry: WIDTH-bit enabled register, async active-high reset to 0.
module regfile_cell
    import urcpu_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) q_d = d_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// URCPU register file: one write port, two registered read ports, per-register pending
// scoreboard that stalls reads of in-flight destinations, and write-to-read bypass.
module regfile_2r1w_sb
    import urcpu_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned NREGS = DefNregs
) (
    input logic              clk,
    input logic              reset,
    regfile_2r1w_sb_if.slave bus
);

    localparam int unsigned AW = addr_width(NREGS);

    logic [NREGS-1:0][WIDTH-1:0] regs;
    logic [NREGS-1:0]            pending_q, pending_d;
    logic                        rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]            rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0]            rs2_data_q, rs2_data_d;
    logic                        wr_hit_rs1, wr_hit_rs2;
    logic                        blocked_rs1, blocked_rs2;
    logic                        rd_stall, accept;

    // R0 has no storage; it is a constant zero.
    assign regs[R0Idx] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cell
        regfile_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .en_i  (bus.we && (bus.waddr == AW'(i))),
            .d_i   (bus.wdata),
            .q_o   (regs[i])
        );
    end

    // Claim applied after the write clear so a same-cycle collision leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (bus.we)       pending_d[bus.waddr]      = 1'b0;
        if (bus.claim_en) pending_d[bus.claim_addr] = 1'b1;
        pending_d[R0Idx] = 1'b0;
    end

    // Hazards use pre-edge pending, so a same-cycle claim never stalls its own read.
    always_comb begin
        wr_hit_rs1  = bus.we && (bus.waddr == bus.rs1_addr);
        wr_hit_rs2  = bus.we && (bus.waddr == bus.rs2_addr);
        blocked_rs1 = pending_q[bus.rs1_addr] && !wr_hit_rs1;
        blocked_rs2 = pending_q[bus.rs2_addr] && !wr_hit_rs2;
        rd_stall    = bus.rd_req && (blocked_rs1 || blocked_rs2);
        accept      = bus.rd_req && !rd_stall;
    end

    always_comb begin
        rd_valid_d = accept;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (accept) begin
            if (bus.rs1_addr == AW'(R0Idx)) rs1_data_d = '0;
            else if (wr_hit_rs1)            rs1_data_d = bus.wdata;
            else                            rs1_data_d = regs[bus.rs1_addr];

            if (bus.rs2_addr == AW'(R0Idx)) rs2_data_d = '0;
            else if (wr_hit_rs2)            rs2_data_d = bus.wdata;
            else                            rs2_data_d = regs[bus.rs2_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            rd_valid_q <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            pending_q  <= pending_d;
            rd_valid_q <= rd_valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign bus.rd_stall = rd_stall;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rs1_data = rs1_data_q;
    assign bus.rs2_data = rs2_data_q;

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Register file read side for the URCPU datapath: 1 write port, 2 registered read ports, 1-cycle read latency.
- Per-register pending scoreboard; stalls a read whose source is claimed by an in-flight instruction.
- Same-cycle write-to-read bypass.
- Sits between decode (issues rd_req/claim) and writeback (drives we).

Parameters:
- WIDTH, 8, data width of each register.
- NREGS, 8, number of registers; R0 reads as zero.
- AW, $clog2(NREGS), address width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- we  in  1  writeback enable.
- waddr  in  AW  writeback register index.
- wdata  in  WIDTH  writeback data.
- claim_en  in  1  mark claim_addr pending (issuing instruction will write it).
- claim_addr  in  AW  register being claimed.
- rd_req  in  1  read request for rs1/rs2.
- rs1_addr  in  AW  source 1 index.
- rs2_addr  in  AW  source 2 index.
- rd_stall  out  1  combinational; request present but blocked by scoreboard.
- rd_valid  out  1  registered; read data valid this cycle.
- rs1_data  out  WIDTH  registered source 1 data.
- rs2_data  out  WIDTH  registered source 2 data.

Behaviour:
- Reset (async, high): all registers 0, pending[] all 0, rd_valid 0, rs1_data/rs2_data 0. Reset asserted mid-read drops rd_valid to 0 the same instant; the request is lost and is not replayed.
- R0:
  - Always reads 0.
  - Writes to R0 are ignored.
  - Claims of R0 are ignored; R0 is never pending.
- Write: on a clock edge with we=1 and waddr!=0, reg[waddr]<=wdata and pending[waddr]<=0.
- Claim:
  - On a clock edge with claim_en=1 and claim_addr!=0, pending[claim_addr]<=1.
  - Claim and write to the same address in the same cycle: claim wins, pending ends 1, reg takes wdata.
- Hazard per source s (s=rs1 or rs2): blocked_s = pending[s_addr] && !(we && waddr==s_addr). A write in the same cycle resolves the hazard.
- rd_stall = rd_req && (blocked_rs1 || blocked_rs2). Purely combinational; no state change because of a stall.
- Accept = rd_req && !rd_stall. On an accepting edge:
  - rd_valid<=1.
  - rsX_data<=0 if the address is 0.
  - else wdata if we && waddr==rsX_addr (bypass).
  - else reg[rsX_addr].
- Latency: data appears on the edge after acceptance (1 cycle).
- Non-accepting edge: rd_valid<=0; rs1_data/rs2_data hold their previous values.
- Back-to-back accepts allowed every cycle; rd_valid stays high continuously.
- Read evaluates hazards against pending state before same-edge claims. A claim in the same cycle as a read of that register does not stall that read; the read returns the pre-claim value.
- rs1_addr==rs2_addr is legal; both outputs carry identical data.

Decomposition:
- Shared package urcpu_pkg: WIDTH default, NREGS default, AW derivation, R0 index constant.
- One sub-module regfile_cell: WIDTH-bit register with enable and async active-high reset to 0, built on the existing reset-flop style.
- Top instantiates NREGS-1 cells (R0 omitted), plus the pending vector, hazard logic, bypass muxes and output registers.

Test Plan:
- Reset: drive reset=1 mid-operation with rd_valid=1 -> rd_valid, rs1_data, rs2_data all 0 immediately; all pending bits 0.
- Write then read:
  - Stimulus: we, waddr=3, wdata=8'hA5; next cycle rd_req, rs1=3, rs2=0.
  - Response: following cycle rd_valid=1, rs1_data=8'hA5, rs2_data=0.
- Bypass:
  - Stimulus: same cycle we, waddr=5, wdata=8'h3C and rd_req, rs1=5, rs2=5.
  - Response: next cycle rs1_data=rs2_data=8'h3C, rd_valid=1.
- Scoreboard stall:
  - Stimulus: claim R2; next cycle rd_req rs1=2 -> rd_stall=1 and rd_valid=0 next edge.
  - Stimulus: then write R2=8'h77 in the stall cycle.
  - Response: rd_stall=0 that cycle; next edge rs1_data=8'h77.
- Claim/write collision:
  - Stimulus: claim_en and we both on R4, wdata=8'h11.
  - Response: a subsequent rd_req rs2=4 stalls; reg[4]=8'h11 after a later write clears pending.
- R0 immunity:
  - Stimulus: we waddr=0 wdata=8'hFF, plus claim R0.
  - Response: rd_req rs1=0 never stalls and returns 0.
